// File: rtl/dmux_stream_router.sv
// Registered 1:CHANNELS stream demultiplexer with optional broadcast.
// Each channel has a one-entry holding slot. Out-of-range selects are dropped and counted.

module dmux_stream_router_slot #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] q
);
  // A load on the same edge as a drain wins, so the slot keeps one word per cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= data;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end
endmodule

module dmux_stream_router #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 8,
  parameter bit BCAST_EN = 1'b1,
  localparam int SEL_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_data,
  input  logic [SEL_W-1:0]          in_sel,
  input  logic                      in_bcast,
  output logic [CHANNELS-1:0]       out_valid,
  input  logic [CHANNELS-1:0]       out_ready,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic [7:0]                drop_count
);
  typedef struct packed {
    logic             bcast;
    logic [SEL_W-1:0] sel;
    logic [WIDTH-1:0] data;
  } req_t;

  localparam logic [SEL_W:0] CH_LIM = (SEL_W+1)'(CHANNELS);

  req_t                             req;
  logic                             in_range;
  logic                             xfer;
  logic [CHANNELS-1:0]              free;
  logic [CHANNELS-1:0]              sel_hit;
  logic [CHANNELS-1:0]              load;
  logic [CHANNELS-1:0][WIDTH-1:0]   slot_q;

  assign req.bcast = BCAST_EN && in_bcast;
  assign req.sel   = in_sel;
  assign req.data  = in_data;

  assign in_range = {1'b0, req.sel} < CH_LIM;
  assign free     = ~out_valid | out_ready;

  // One-hot decode avoids indexing past CHANNELS for unused select codes.
  always_comb begin
    in_ready = 1'b1;
    if (req.bcast)     in_ready = &free;
    else if (in_range) in_ready = |(sel_hit & free);
  end

  assign xfer = in_valid && in_ready;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    assign sel_hit[i] = (req.sel == SEL_W'(i));
    assign load[i]    = xfer && (req.bcast || (in_range && sel_hit[i]));

    dmux_stream_router_slot #(.WIDTH(WIDTH)) u_slot (
      .clk   (clk),
      .reset (reset),
      .load  (load[i]),
      .data  (req.data),
      .ready (out_ready[i]),
      .valid (out_valid[i]),
      .q     (slot_q[i])
    );
  end

  assign out_data = slot_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      drop_count <= 8'd0;
    else if (xfer && !req.bcast && !in_range && drop_count != 8'hFF)
      drop_count <= drop_count + 8'd1;
  end
endmodule

// File: tb/tb_dmux_stream_router.sv
// Directed bench for dmux_stream_router: three instances cover 8 channels,
// 6 channels (unused select codes) and broadcast disabled.
module tb_dmux_stream_router;
  int checks = 0;
  int errors = 0;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // dut0: WIDTH 16, CHANNELS 8, broadcast enabled
  logic         v0 = 0, bc0 = 0, rdy0;
  logic [2:0]   sel0 = 0;
  logic [15:0]  d0 = 0;
  logic [7:0]   ordy0 = 0, ov0, dc0;
  logic [127:0] od0;

  // dut1: WIDTH 16, CHANNELS 6
  logic         v1 = 0, bc1 = 0, rdy1;
  logic [2:0]   sel1 = 0;
  logic [15:0]  d1 = 0;
  logic [5:0]   ordy1 = 0, ov1;
  logic [7:0]   dc1;
  logic [95:0]  od1;

  // dut2: WIDTH 16, CHANNELS 8, broadcast disabled
  logic         v2 = 0, bc2 = 0, rdy2;
  logic [2:0]   sel2 = 0;
  logic [15:0]  d2 = 0;
  logic [7:0]   ordy2 = 0, ov2, dc2;
  logic [127:0] od2;

  dmux_stream_router #(.WIDTH(16), .CHANNELS(8), .BCAST_EN(1'b1)) dut0 (
    .clk(clk), .reset(reset), .in_valid(v0), .in_ready(rdy0), .in_data(d0),
    .in_sel(sel0), .in_bcast(bc0), .out_valid(ov0), .out_ready(ordy0),
    .out_data(od0), .drop_count(dc0));

  dmux_stream_router #(.WIDTH(16), .CHANNELS(6), .BCAST_EN(1'b1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(v1), .in_ready(rdy1), .in_data(d1),
    .in_sel(sel1), .in_bcast(bc1), .out_valid(ov1), .out_ready(ordy1),
    .out_data(od1), .drop_count(dc1));

  dmux_stream_router #(.WIDTH(16), .CHANNELS(8), .BCAST_EN(1'b0)) dut2 (
    .clk(clk), .reset(reset), .in_valid(v2), .in_ready(rdy2), .in_data(d2),
    .in_sel(sel2), .in_bcast(bc2), .out_valid(ov2), .out_ready(ordy2),
    .out_data(od2), .drop_count(dc2));

  // Advance to just after the next rising edge; inputs change and outputs are sampled here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (ov0 !== 8'h00 || od0 !== '0 || dc0 !== 8'd0) begin
      errors++; $display("FAIL reset_state got ov=%h dc=%0d od=%h want 00/0/0", ov0, dc0, od0);
    end
    checks++;
    if (rdy0 !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready got %b want 1", rdy0);
    end
    @(negedge clk);
    reset = 1'b0;
    step();
  endtask

  task automatic test_unicast();
    v0 = 1; sel0 = 3'd5; d0 = 16'hBEEF; ordy0 = 8'h00;
    #1;
    checks++;
    if (rdy0 !== 1'b1) begin errors++; $display("FAIL uni_ready got %b want 1", rdy0); end
    step();
    checks++;
    if (ov0 !== 8'h20 || od0[5*16 +: 16] !== 16'hBEEF) begin
      errors++; $display("FAIL uni_load got ov=%h s5=%h want 20/beef", ov0, od0[5*16 +: 16]);
    end
    d0 = 16'h1111;
    #1;
    checks++;
    if (rdy0 !== 1'b0) begin errors++; $display("FAIL uni_full_ready got %b want 0", rdy0); end
    step();
    checks++;
    if (ov0 !== 8'h20 || od0[5*16 +: 16] !== 16'hBEEF) begin
      errors++; $display("FAIL uni_hold got ov=%h s5=%h want 20/beef", ov0, od0[5*16 +: 16]);
    end
    sel0 = 3'd2; d0 = 16'h2222;
    #1;
    checks++;
    if (rdy0 !== 1'b1) begin errors++; $display("FAIL uni_other_ready got %b want 1", rdy0); end
    step();
    v0 = 0;
    checks++;
    if (ov0 !== 8'h24 || od0[2*16 +: 16] !== 16'h2222) begin
      errors++; $display("FAIL uni_sel2 got ov=%h s2=%h want 24/2222", ov0, od0[2*16 +: 16]);
    end
  endtask

  task automatic test_streaming();
    ordy0 = 8'h08;
    for (int k = 1; k <= 10; k++) begin
      v0 = 1; sel0 = 3'd3; d0 = 16'(k);
      #1;
      checks++;
      if (rdy0 !== 1'b1) begin errors++; $display("FAIL stream_ready[%0d] got %b want 1", k, rdy0); end
      step();
      checks++;
      if (ov0[3] !== 1'b1 || od0[3*16 +: 16] !== 16'(k)) begin
        errors++; $display("FAIL stream_word[%0d] got v=%b s3=%h want 1/%h", k, ov0[3], od0[3*16 +: 16], 16'(k));
      end
    end
    v0 = 0;
    step();
    checks++;
    if (ov0 !== 8'h24) begin errors++; $display("FAIL stream_drain got ov=%h want 24", ov0); end
    ordy0 = 8'h00;
  endtask

  task automatic test_broadcast();
    ordy0 = 8'h24;
    step();
    ordy0 = 8'h00;
    v0 = 1; sel0 = 3'd6; d0 = 16'h0066;
    step();
    v0 = 1; bc0 = 1; sel0 = 3'd0; d0 = 16'h1234;
    #1;
    checks++;
    if (ov0 !== 8'h40 || rdy0 !== 1'b0) begin
      errors++; $display("FAIL bcast_stall got ov=%h rdy=%b want 40/0", ov0, rdy0);
    end
    step();
    checks++;
    if (ov0 !== 8'h40 || od0[6*16 +: 16] !== 16'h0066) begin
      errors++; $display("FAIL bcast_hold got ov=%h s6=%h want 40/0066", ov0, od0[6*16 +: 16]);
    end
    ordy0 = 8'h40;
    #1;
    checks++;
    if (rdy0 !== 1'b1) begin errors++; $display("FAIL bcast_ready got %b want 1", rdy0); end
    step();
    v0 = 0; bc0 = 0; ordy0 = 8'h00;
    checks++;
    if (ov0 !== 8'hFF) begin errors++; $display("FAIL bcast_valid got %h want ff", ov0); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (od0[i*16 +: 16] !== 16'h1234) begin
        errors++; $display("FAIL bcast_slice[%0d] got %h want 1234", i, od0[i*16 +: 16]);
      end
    end
    ordy0 = 8'hFF;
    step();
    ordy0 = 8'h00;
    checks++;
    if (ov0 !== 8'h00) begin errors++; $display("FAIL bcast_drain got %h want 00", ov0); end
  endtask

  task automatic test_drop();
    int bad_ready;
    bad_ready = 0;
    v1 = 1; sel1 = 3'd1; d1 = 16'hAAAA;
    step();
    for (int k = 1; k <= 300; k++) begin
      sel1 = (k % 2 == 0) ? 3'd6 : 3'd7;
      d1 = 16'(k);
      #1;
      if (rdy1 !== 1'b1) bad_ready++;
      step();
      if (k == 10) begin
        checks++;
        if (dc1 !== 8'd10) begin errors++; $display("FAIL drop_count_10 got %0d want 10", dc1); end
      end
    end
    v1 = 0;
    checks++;
    if (bad_ready != 0) begin errors++; $display("FAIL drop_ready got %0d stalls want 0", bad_ready); end
    checks++;
    if (dc1 !== 8'd255) begin errors++; $display("FAIL drop_saturate got %0d want 255", dc1); end
    checks++;
    if (ov1 !== 6'h02 || od1[1*16 +: 16] !== 16'hAAAA) begin
      errors++; $display("FAIL drop_untouched got ov=%h s1=%h want 02/aaaa", ov1, od1[1*16 +: 16]);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) begin
      v0 = 1; sel0 = 3'(i); d0 = 16'(16'hA0 + i);
      step();
    end
    v0 = 0;
    checks++;
    if (ov0 !== 8'h0F) begin errors++; $display("FAIL mid_setup got %h want 0f", ov0); end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (ov0 !== 8'h00 || dc1 !== 8'd0 || ov1 !== 6'h00) begin
      errors++; $display("FAIL mid_async got ov0=%h dc1=%0d ov1=%h want 00/0/00", ov0, dc1, ov1);
    end
    #1;
    reset = 1'b0;
    v0 = 1; sel0 = 3'd4; d0 = 16'h4444;
    step();
    v0 = 0;
    checks++;
    if (ov0 !== 8'h10 || od0[4*16 +: 16] !== 16'h4444) begin
      errors++; $display("FAIL mid_first got ov=%h s4=%h want 10/4444", ov0, od0[4*16 +: 16]);
    end
  endtask

  task automatic test_no_bcast();
    v2 = 1; bc2 = 1; sel2 = 3'd1; d2 = 16'h5A5A; ordy2 = 8'h00;
    #1;
    checks++;
    if (rdy2 !== 1'b1) begin errors++; $display("FAIL nobc_ready got %b want 1", rdy2); end
    step();
    v2 = 0; bc2 = 0;
    checks++;
    if (ov2 !== 8'h02 || od2[1*16 +: 16] !== 16'h5A5A) begin
      errors++; $display("FAIL nobc_unicast got ov=%h s1=%h want 02/5a5a", ov2, od2[1*16 +: 16]);
    end
  endtask

  initial begin
    test_reset();
    test_unicast();
    test_streaming();
    test_broadcast();
    test_drop();
    test_reset_mid();
    test_no_bcast();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dmux_stream_router.md
Name: dmux_stream_router

Overview:
Parametrised, registered successor to the fixed 8-way single-bit demultiplexer. It routes a WIDTH-bit valid/ready stream to one of CHANNELS output channels selected per word, and can optionally broadcast a word to all channels. Each output channel has a one-entry holding register, so the block adds backpressure and 1-cycle latency. Words whose select is out of range are dropped and counted. It sits between a single producer and a bank of per-channel consumers in the datapath.

Parameters:
WIDTH, 16, data word width in bits (>=1).
CHANNELS, 8, number of output channels (2..64; need not be a power of two).
SEL_W, derived localparam = max(1, clog2(CHANNELS)), width of in_sel; not overridable.
BCAST_EN, 1, 1 = in_bcast honoured; 0 = in_bcast ignored and treated as 0.

Ports:
clk  input  1  single clock; all state updates on rising edge.
reset  input  1  asynchronous, active-high reset.
in_valid  input  1  producer has a word.
in_ready  output  1  block can accept the word presented this cycle.
in_data  input  WIDTH  word to route.
in_sel  input  SEL_W  destination channel index.
in_bcast  input  1  1 = deliver the word to every channel; in_sel ignored.
out_valid  output  CHANNELS  bit i = channel i holds a word.
out_ready  input  CHANNELS  bit i = consumer i takes the word this cycle.
out_data  output  CHANNELS*WIDTH  channel i word at bits [i*WIDTH +: WIDTH].
drop_count  output  8  saturating count of dropped (out-of-range) words.

Behaviour:
- Reset (async assert, sync release): out_valid = 0, every out_data slice = 0, drop_count = 0. Held words are discarded. in_ready is computed combinationally from out_valid, so it reads 1 during reset.
- Slot i is free when !out_valid[i] || out_ready[i]; a slot being drained this cycle counts as free.
- in_ready (combinational from in_sel, in_bcast, out_valid, out_ready; must never depend on in_valid):
  - broadcast: AND of all slots free.
  - unicast with in_sel < CHANNELS: slot[in_sel] free.
  - unicast with in_sel >= CHANNELS: 1.
- Transfer = in_valid && in_ready at a rising edge. After that edge:
  - unicast in range: out_valid[in_sel] = 1 and slice in_sel = in_data.
  - broadcast: all out_valid = 1 and all slices = in_data.
  - out of range: no channel changes; drop_count increments, saturating at 255.
- Latency: a word accepted at edge k is visible on out_data/out_valid after edge k. No combinational path from in_data to out_data.
- Drain: out_valid[i] && out_ready[i] at an edge clears out_valid[i], unless the same edge loads slot i, in which case out_valid[i] stays 1 and the data is replaced. This sustains 1 word/cycle per channel.
- Hold: while out_valid[i] && !out_ready[i], out_data slice i and out_valid[i] stay stable.
- A cleared slot's out_data keeps its last value; consumers must qualify with out_valid.
- Channels are independent: a stalled channel blocks only words addressed to it (and broadcasts). Per-channel order equals input order.
- out_ready[i] while out_valid[i] = 0 has no effect.
- When CHANNELS is not a power of two, the unused in_sel codes are the out-of-range codes.

Test Plan:
- Reset then unicast: WIDTH=16, CHANNELS=8; in_sel=5, in_data=0xBEEF, out_ready=0 -> after 1 edge out_valid=0x20, slice5=0xBEEF; a second word to sel 5 sees in_ready=0; a word to sel 2 is accepted.
- Streaming: out_ready[3]=1, 10 back-to-back words 1..10 to sel 3 -> in_ready held 1, out_valid[3] stays 1, slice3 shows 1..10 on consecutive cycles.
- Broadcast: slot 6 full and stalled, in_bcast=1, data 0x1234 -> in_ready=0 until out_ready[6]=1; on that edge out_valid=0xFF and all slices = 0x1234.
- Drop: CHANNELS=6, in_sel=7, 300 transfers -> in_ready=1 throughout, out_valid unchanged, drop_count saturates at 255.
- Reset mid-operation: out_valid=0x0F, async reset pulse between edges -> out_valid=0x00 and drop_count=0 immediately; the first post-release word routes normally.
- BCAST_EN=0: in_bcast=1, in_sel=1 -> only out_valid[1] sets.
